// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding, flag bit positions and opcode helpers for the pipelined ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: op_e (4-bit opcode enum), FLAG_* indices into the {Z,N,C,V} flag
// vector, and is_acc_op() which marks the opcodes that write the accumulator.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'b0000,
        OP_SUB     = 4'b0001,
        OP_AND     = 4'b0010,
        OP_OR      = 4'b0011,
        OP_XOR     = 4'b0100,
        OP_NOT     = 4'b0101,
        OP_SHL     = 4'b0110,
        OP_SHR     = 4'b0111,
        OP_ACC_ADD = 4'b1000,
        OP_ACC_SUB = 4'b1001,
        OP_ACC_LD  = 4'b1010,
        OP_ACC_CLR = 4'b1011,
        OP_INC     = 4'b1100,
        OP_DEC     = 4'b1101,
        OP_PASS_B  = 4'b1110,
        OP_PASS_A  = 4'b1111
    } op_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // The four accumulator opcodes share the 10xx prefix.
    function automatic logic is_acc_op(input op_e op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: op/A/B/ACC -> result, {Z,N,C,V} flags, accumulator write enable.
// Latency: 0 cycles (purely combinational, used inside the second pipeline stage).
// Backpressure: none; the enclosing pipeline decides when the outputs are captured.
//
// Ports: op_i opcode, a_i/b_i operands, acc_i current accumulator,
//        result_o result, flags_o {Z,N,C,V}, acc_we_o accumulator write enable.
// Build option: define ALU_PIPE_SAT_EN to clamp add-type results to all-ones
// on carry and sub-type results to zero on borrow; C/V always describe the
// unclamped operation, Z/N describe the value actually produced.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o,
    output logic             acc_we_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] opx;
    logic [WIDTH-1:0] opy;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] res;
    logic             c_flag;
    logic             v_flag;

    // One shared adder and one shared subtractor; the opcode only steers
    // which values feed them (ACC ops use ACC as the left operand, INC/DEC
    // use a constant one on the right).
    always_comb begin
        opx = a_i;
        opy = b_i;
        case (op_i)
            OP_ACC_ADD, OP_ACC_SUB: begin
                opx = acc_i;
                opy = a_i;
            end
            OP_INC, OP_DEC: opy = ONE;
            default: ;
        endcase
    end

    // Extra top bit holds carry-out for the add and borrow for the subtract.
    assign sum_w  = {1'b0, opx} + {1'b0, opy};
    assign diff_w = {1'b0, opx} - {1'b0, opy};

    // Signed overflow: add overflows when like-signed operands give a result
    // of the other sign; subtract when unlike-signed operands do.
    assign add_ovf = (opx[WIDTH-1] == opy[WIDTH-1]) && (sum_w[WIDTH-1]  != opx[WIDTH-1]);
    assign sub_ovf = (opx[WIDTH-1] != opy[WIDTH-1]) && (diff_w[WIDTH-1] != opx[WIDTH-1]);

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op_i)
            OP_ADD, OP_ACC_ADD, OP_INC: begin
`ifdef ALU_PIPE_SAT_EN
                res = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
`else
                res = sum_w[WIDTH-1:0];
`endif
                c_flag = sum_w[WIDTH];
                v_flag = add_ovf;
            end
            OP_SUB, OP_ACC_SUB, OP_DEC: begin
`ifdef ALU_PIPE_SAT_EN
                res = diff_w[WIDTH] ? '0 : diff_w[WIDTH-1:0];
`else
                res = diff_w[WIDTH-1:0];
`endif
                c_flag = diff_w[WIDTH];
                v_flag = sub_ovf;
            end
            OP_AND:     res = a_i & b_i;
            OP_OR:      res = a_i | b_i;
            OP_XOR:     res = a_i ^ b_i;
            OP_NOT:     res = ~a_i;
            OP_SHL: begin
                res    = {a_i[WIDTH-2:0], 1'b0};
                c_flag = a_i[WIDTH-1];
            end
            OP_SHR: begin
                res    = {1'b0, a_i[WIDTH-1:1]};
                c_flag = a_i[0];
            end
            OP_ACC_LD:  res = a_i;
            OP_ACC_CLR: res = '0;
            OP_PASS_B:  res = b_i;
            OP_PASS_A:  res = a_i;
            default:    res = '0;
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_Z] = (res == '0);
        flags_o[FLAG_N] = res[WIDTH-1];
        flags_o[FLAG_C] = c_flag;
        flags_o[FLAG_V] = v_flag;
    end

    assign result_o = res;
    assign acc_we_o = is_acc_op(op_i);

endmodule

// File: rtl/alu_pipe_acc.sv
// Two-stage pipelined ALU with accumulator and {Z,N,C,V} flags behind valid/ready handshakes.
// Latency: 2 cycles from input accept to out_valid; 1 op/cycle sustained when out_ready=1.
// Backpressure: out_ready low stalls stage 2, then stage 1; in_ready drops once both are full.
//
// Ports: clk, rst (async, active high); in_valid/in_ready/in_op/in_a/in_b input
//        handshake; out_valid/out_ready/out_result/out_flags output handshake;
//        acc_value registered accumulator.
// Build option: ALU_PIPE_SAT_EN selects unsigned saturation (see alu_pipe_core).
module alu_pipe_acc
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [WIDTH-1:0] acc_value
);

    // Stage 1: captured operation.
    logic             s1_vld_q, s1_vld_d;
    op_e              s1_op_q,  s1_op_d;
    logic [WIDTH-1:0] s1_a_q,   s1_a_d;
    logic [WIDTH-1:0] s1_b_q,   s1_b_d;

    // Stage 2: computed result, which is also the output register.
    logic             s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic [3:0]       s2_flg_q, s2_flg_d;

    logic [WIDTH-1:0] acc_q,    acc_d;

    logic             s2_adv;
    logic             in_fire;
    logic [WIDTH-1:0] core_res;
    logic [3:0]       core_flg;
    logic             core_acc_we;

    alu_pipe_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i     (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .acc_i    (acc_q),
        .result_o (core_res),
        .flags_o  (core_flg),
        .acc_we_o (core_acc_we)
    );

    // Stage 1 moves into stage 2 when stage 2 is empty or being drained.
    // ACC is only read and written at this single point, so consecutive ACC
    // ops are naturally serialised in program order.
    assign s2_adv   = s1_vld_q && (!s2_vld_q || out_ready);
    assign in_ready = !rst && (!s1_vld_q || s2_adv);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_op_d  = s1_op_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s2_vld_d = s2_vld_q;
        s2_res_d = s2_res_q;
        s2_flg_d = s2_flg_q;
        acc_d    = acc_q;

        if (in_fire) begin
            s1_vld_d = 1'b1;
            s1_op_d  = op_e'(in_op);
            s1_a_d   = in_a;
            s1_b_d   = in_b;
        end else if (s2_adv) begin
            s1_vld_d = 1'b0;
        end

        // Result/flags only change on a new entry, so they stay frozen while
        // the downstream stalls.
        if (s2_adv) begin
            s2_vld_d = 1'b1;
            s2_res_d = core_res;
            s2_flg_d = core_flg;
            if (core_acc_we) begin
                acc_d = core_res;
            end
        end else if (out_ready) begin
            s2_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_op_q  <= OP_ADD;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_res_q <= '0;
            s2_flg_q <= '0;
            acc_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_op_q  <= s1_op_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s2_vld_q <= s2_vld_d;
            s2_res_q <= s2_res_d;
            s2_flg_q <= s2_flg_d;
            acc_q    <= acc_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign out_result = s2_res_q;
    assign out_flags  = s2_flg_q;
    assign acc_value  = acc_q;

endmodule
